hazard_ctrl_mc: RTL and testbench
=================================

// Module: hazard_ctrl_mc
// PURPOSE
//  Next-generation hazard unit for the 5-stage RV pipeline. Adds to the single-cycle scheme:
//  - forwarding on/off mode
//  - x0-aware load-use detection
//  - a sequencer that stalls IF/ID/EX while a multi-cycle M-extension unit (MDU) runs
//  - optional stall/flush performance counters
//  Sits beside the datapath; drives stage-register enables/clears and EX operand muxes.
// PARAMETERS
//  REG_AW        5   register address width (5 = RV32I, 4 = RV32E)
//  FWD_EN        1   1: forward from M/W; 0: no forwarding, resolve RAW by stalling in D
//  RF_WR_FIRST   1   1: RF write-first (W->D needs no stall); 0: W match also stalls when FWD_EN=0
//  CNT_W         32  perf counter width (used only with HAZARD_PERF_CNT_EN)
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        async active-low reset
//  Rs1D,Rs2D     in   REG_AW   source regs in D
//  Rs1E,Rs2E,RdE in   REG_AW   sources/dest in E
//  RdM,RdW       in   REG_AW   dest in M/W
//  RegWriteE/M/W in   1        stage writes RF
//  ResultSrcb0E  in   1        instr in E is a load
//  PCSrcE        in   1        taken branch/jump resolved in E
//  MdOpE         in   1        instr in E is a multi-cycle MDU op
//  MdDoneE       in   1        MDU result valid (single-cycle pulse)
//  PerfClr       in   1        sync clear of perf counters (ignored if macro off)
//  ForwardAE/BE  out  2        00 RF, 01 from W, 10 from M
//  StallF,StallD,StallE out 1  hold PC / IF-ID / ID-EX registers
//  FlushD,FlushE,FlushM out 1  clear IF-ID / ID-EX / EX-MEM registers
//  MdStartE      out  1        one-cycle MDU start pulse
//  MdBusy        out  1        sequencer in BUSY
//  StallCnt,FlushCnt out CNT_W perf counters (present only with macro)
// BEHAVIOUR
//  - Reset: FSM=IDLE; MdBusy=0; counters=0. All comb outputs follow inputs, 0 with zero inputs.
//  - Forwarding (FWD_EN=1), per operand, M beats W, x0 never forwarded:
//    - ForwardAE=10 if Rs1E==RdM & RegWriteM & Rs1E!=0
//    - else 01 if Rs1E==RdW & RegWriteW & Rs1E!=0
//    - else 00. ForwardBE same with Rs2E.
//    - FWD_EN=0: ForwardAE/BE tied 00.
//  - lwStall = ResultSrcb0E & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
//  - rawStall (FWD_EN=0 only): Rs1D or Rs2D nonzero and equal to:
//    - RdE with RegWriteE, or RdM with RegWriteM
//    - or RdW with RegWriteW when RF_WR_FIRST=0
//  - dStall = lwStall | rawStall -> StallF=StallD=1, FlushE=1 (bubble into E).
//  - Branch: FlushD=PCSrcE; FlushE|=PCSrcE. PCSrcE wins over dStall: StallF/StallD forced 0 when PCSrcE.
//  - MDU FSM, states IDLE, BUSY:
//    - IDLE & MdOpE: MdStartE=1 (comb), StallF=StallD=StallE=1, FlushM=1; next BUSY.
//    - BUSY & !MdDoneE: StallF/D/E=1, FlushM=1, MdBusy=1.
//    - BUSY & MdDoneE: stalls released, FlushM=0 (MDU result moves to M); next IDLE.
//    - Latency: MDU taking N cycles after start costs N+1 stall cycles (start cycle included).
//    - MdDoneE in IDLE: ignored.
//    - MdOpE in BUSY: no re-start.
//    - In IDLE/BUSY, FlushE and FlushD from dStall/PCSrcE are masked while StallE=1 (E holds an MDU op, not a branch).
//    - rst_n low mid-op: FSM->IDLE immediately; MDU must also reset.
//  - No state other than FSM and counters; all other outputs are combinational.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    - StallCnt +1 each cycle StallD=1
//    - FlushCnt +1 each cycle FlushE=1
//    - both saturate at all-ones; PerfClr zeroes both next edge (priority over increment)
//  Undefined: counter ports, PerfClr logic and registers are absent; PerfClr is left as an unused input.
// TESTING
//  1. FWD_EN=1, RdM=5 RegWriteM=1, RdW=5 RegWriteW=1, Rs1E=5 -> ForwardAE=10; Rs1E=0 -> 00.
//  2. ResultSrcb0E=1 RdE=7 Rs2D=7 -> StallF=StallD=FlushE=1 one cycle; RdE=0 -> no stall.
//  3. MdOpE=1, MdDoneE 4 cycles later -> MdStartE 1 cycle, StallE=FlushM=1 for 5 cycles, MdBusy 4, then IDLE.
//  4. rst_n=0 in BUSY cycle 2 -> MdBusy=0, stalls drop; MdOpE next -> fresh MdStartE.
//  5. FWD_EN=0, RdM=3 RegWriteM=1, Rs1D=3 -> StallD=1, ForwardAE=00; PCSrcE=1 same cycle -> StallD=0, FlushD=FlushE=1.
//  6. Macro on: 3 load-use stalls + 2 branches -> StallCnt=3, FlushCnt=5; PerfClr -> 0; CNT_W=2, 5 stalls -> StallCnt=3.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// Hazard unit for the 5-stage RV pipeline: forwarding, load-use/RAW stalls, branch flush
// and an IDLE/BUSY sequencer for multi-cycle MDU ops. Perf counters with HAZARD_PERF_CNT_EN.
module hazard_ctrl_mc #(
    parameter int REG_AW      = 5,
    parameter int FWD_EN      = 1,
    parameter int RF_WR_FIRST = 1,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcb0E,
    input  logic              PCSrcE,
    input  logic              MdOpE,
    input  logic              MdDoneE,
    input  logic              PerfClr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MdStartE,
    output logic              MdBusy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
`endif
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t         state_q, state_d;
    logic              md_stall;
    logic              lw_stall, raw_stall, d_stall;
    logic [REG_AW-1:0] src_d [2];
    logic [1:0]        lw_hit, raw_hit;

    assign src_d[0] = Rs1D;
    assign src_d[1] = Rs2D;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign lw_hit[gi]  = (RdE != '0) && (src_d[gi] == RdE);
            // Without forwarding any in-flight producer of a nonzero source must drain first.
            assign raw_hit[gi] = (src_d[gi] != '0) &&
                                 ((src_d[gi] == RdE && RegWriteE) ||
                                  (src_d[gi] == RdM && RegWriteM) ||
                                  ((RF_WR_FIRST == 0) && src_d[gi] == RdW && RegWriteW));
        end

        if (FWD_EN != 0) begin : g_fwd
            always_comb begin
                ForwardAE = 2'b00;
                if (Rs1E != '0 && Rs1E == RdM && RegWriteM)      ForwardAE = 2'b10;
                else if (Rs1E != '0 && Rs1E == RdW && RegWriteW) ForwardAE = 2'b01;
                ForwardBE = 2'b00;
                if (Rs2E != '0 && Rs2E == RdM && RegWriteM)      ForwardBE = 2'b10;
                else if (Rs2E != '0 && Rs2E == RdW && RegWriteW) ForwardBE = 2'b01;
            end
        end else begin : g_nofwd
            assign ForwardAE = 2'b00;
            assign ForwardBE = 2'b00;
        end
    endgenerate

    assign lw_stall  = ResultSrcb0E && (|lw_hit);
    assign raw_stall = (FWD_EN == 0) && (|raw_hit);
    assign d_stall   = lw_stall || raw_stall;

    always_comb begin
        state_d  = state_q;
        md_stall = 1'b0;
        MdStartE = 1'b0;
        MdBusy   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MdOpE) begin
                    MdStartE = 1'b1;
                    md_stall = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (MdDoneE) begin
                    state_d = IDLE;
                end else begin
                    md_stall = 1'b1;
                    MdBusy   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // While E holds an MDU op, branch/bubble flushes must not destroy it.
    assign StallF = md_stall || (d_stall && !PCSrcE);
    assign StallD = StallF;
    assign StallE = md_stall;
    assign FlushM = md_stall;
    assign FlushD = PCSrcE && !md_stall;
    assign FlushE = (d_stall || PCSrcE) && !md_stall;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (PerfClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (StallD && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            if (FlushE && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = PerfClr;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: one forwarding instance and one stall-only
// instance (RF not write-first, 2-bit counters) driven by the same stimulus.
module tb_hazard_ctrl_mc;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteE, RegWriteM, RegWriteW, ResultSrcb0E, PCSrcE, MdOpE, MdDoneE, PerfClr;

    logic [1:0] fa0, fb0, fa1, fb1;
    logic sf0, sd0, se0, fd0, fe0, fm0, st0, bz0;
    logic sf1, sd1, se1, fd1, fe1, fm1, st1, bz1;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] scnt0, fcnt0;
    logic [1:0]  scnt1, fcnt1;
`endif

    hazard_ctrl_mc #(.REG_AW(AW), .FWD_EN(1), .RF_WR_FIRST(1), .CNT_W(32)) u_dut_fwd (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcb0E(ResultSrcb0E), .PCSrcE(PCSrcE), .MdOpE(MdOpE),
        .MdDoneE(MdDoneE), .PerfClr(PerfClr), .ForwardAE(fa0), .ForwardBE(fb0),
        .StallF(sf0), .StallD(sd0), .StallE(se0), .FlushD(fd0), .FlushE(fe0), .FlushM(fm0),
        .MdStartE(st0), .MdBusy(bz0)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCnt(scnt0), .FlushCnt(fcnt0)
`endif
    );

    hazard_ctrl_mc #(.REG_AW(AW), .FWD_EN(0), .RF_WR_FIRST(0), .CNT_W(2)) u_dut_nofwd (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcb0E(ResultSrcb0E), .PCSrcE(PCSrcE), .MdOpE(MdOpE),
        .MdDoneE(MdDoneE), .PerfClr(PerfClr), .ForwardAE(fa1), .ForwardBE(fb1),
        .StallF(sf1), .StallD(sd1), .StallE(se1), .FlushD(fd1), .FlushE(fe1), .FlushM(fm1),
        .MdStartE(st1), .MdBusy(bz1)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCnt(scnt1), .FlushCnt(fcnt1)
`endif
    );

    // Packed view: [11:10] FwdA [9:8] FwdB [7] StallF [6] StallD [5] StallE
    //              [4] FlushD [3] FlushE [2] FlushM [1] MdStartE [0] MdBusy
    logic [11:0] obs0, obs1, last0, last1;
    assign obs0 = {fa0, fb0, sf0, sd0, se0, fd0, fe0, fm0, st0, bz0};
    assign obs1 = {fa1, fb1, sf1, sd1, se1, fd1, fe1, fm1, st1, bz1};

    typedef struct packed {
        logic [11:0] e0;
        logic [11:0] e1;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mbusy    = 1'b0;
    bit cnt_md   = 1'b0;
    int n_se = 0, n_bz = 0, n_st = 0;
    logic [31:0] m_sc0 = '0, m_fc0 = '0;
    logic [1:0]  m_sc1 = '0, m_fc1 = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic dep(input logic [AW-1:0] rs, input bit wr_first);
        if (rs == '0) return 1'b0;
        return (rs == RdE && RegWriteE) || (rs == RdM && RegWriteM) ||
               (!wr_first && rs == RdW && RegWriteW);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs);
        if (rs == '0) return 2'b00;
        if (rs == RdM && RegWriteM) return 2'b10;
        if (rs == RdW && RegWriteW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] model(input bit fwd, input bit wr_first);
        logic [1:0] fa, fb;
        logic lw, raw, ds, md, stl, start, busy, fd, fe;
        fa    = fwd ? fwd_sel(Rs1E) : 2'b00;
        fb    = fwd ? fwd_sel(Rs2E) : 2'b00;
        lw    = ResultSrcb0E && RdE != '0 && (Rs1D == RdE || Rs2D == RdE);
        raw   = !fwd && (dep(Rs1D, wr_first) || dep(Rs2D, wr_first));
        ds    = lw || raw;
        start = !mbusy && MdOpE;
        busy  = mbusy && !MdDoneE;
        md    = start || busy;
        stl   = md || (ds && !PCSrcE);
        fd    = PCSrcE && !md;
        fe    = (ds || PCSrcE) && !md;
        return {fa, fb, stl, stl, md, fd, fe, md, start, busy};
    endfunction

    task automatic step(input string tag);
        exp_t e;
        if (!rst_n) mbusy = 1'b0;
        e.e0 = model(1'b1, 1'b1);
        e.e1 = model(1'b0, 1'b0);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        last0 = obs0;
        last1 = obs1;
        check_eq({tag, "/fwd"}, 32'(obs0), 32'(e.e0));
        check_eq({tag, "/nofwd"}, 32'(obs1), 32'(e.e1));
`ifdef HAZARD_PERF_CNT_EN
        check_eq({tag, "/scnt0"}, scnt0, m_sc0);
        check_eq({tag, "/fcnt0"}, fcnt0, m_fc0);
        check_eq({tag, "/scnt1"}, 32'(scnt1), 32'(m_sc1));
        check_eq({tag, "/fcnt1"}, 32'(fcnt1), 32'(m_fc1));
`endif
        if (cnt_md) begin
            if (obs0[5]) n_se++;
            if (obs0[0]) n_bz++;
            if (obs0[1]) n_st++;
        end
        $display("%0t %s fwd=%03h nofwd=%03h", $time, tag, obs0, obs1);
        @(posedge clk);
        if (!rst_n || PerfClr) begin
            m_sc0 = '0; m_fc0 = '0; m_sc1 = '0; m_fc1 = '0;
        end else begin
            if (e.e0[6] && m_sc0 != '1) m_sc0++;
            if (e.e0[3] && m_fc0 != '1) m_fc0++;
            if (e.e1[6] && m_sc1 != '1) m_sc1++;
            if (e.e1[3] && m_fc1 != '1) m_fc1++;
        end
        if (!rst_n)                  mbusy = 1'b0;
        else if (!mbusy && MdOpE)    mbusy = 1'b1;
        else if (mbusy && MdDoneE)   mbusy = 1'b0;
        #1;
    endtask

    task automatic clr();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcb0E = 0;
        PCSrcE = 0; MdOpE = 0; MdDoneE = 0; PerfClr = 0;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        step("reset");
        check_eq("reset_outs", 32'(last0), 32'd0);
        rst_n = 1'b1;
        step("idle");

        // forwarding priority and x0
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        step("fwd_m");
        check_eq("fwd_m_beats_w", 32'(last0[11:10]), 32'd2);
        Rs1E = 0;
        step("fwd_x0");
        check_eq("fwd_x0", 32'(last0[11:10]), 32'd0);
        RdM = 6; Rs2E = 5;
        step("fwd_w");
        check_eq("fwd_w_b", 32'(last0[9:8]), 32'd1);
        clr();

        // load-use
        ResultSrcb0E = 1; RdE = 7; Rs2D = 7;
        step("lw_use");
        check_eq("lw_stallD", 32'(last0[6]), 32'd1);
        check_eq("lw_flushE", 32'(last0[3]), 32'd1);
        RdE = 0; Rs2D = 0;
        step("lw_x0");
        check_eq("lw_x0_nostall", 32'(last0[6]), 32'd0);
        clr();

        // no-forwarding RAW stall, branch wins
        RdM = 3; RegWriteM = 1; Rs1D = 3; Rs1E = 3;
        step("raw_m");
        check_eq("raw_stallD", 32'(last1[6]), 32'd1);
        check_eq("raw_fwdA", 32'(last1[11:10]), 32'd0);
        PCSrcE = 1;
        step("raw_br");
        check_eq("raw_br_stallD", 32'(last1[6]), 32'd0);
        check_eq("raw_br_flushD", 32'(last1[4]), 32'd1);
        clr();
        RdW = 4; RegWriteW = 1; Rs2D = 4;
        step("raw_w");
        check_eq("raw_w_stall", 32'(last1[6]), 32'd1);
        check_eq("raw_w_fwd_nostall", 32'(last0[6]), 32'd0);
        clr();

        // MDU op, 4 cycles after start
        cnt_md = 1'b1; n_se = 0; n_bz = 0; n_st = 0;
        MdOpE = 1;
        step("md_start");
        repeat (2) step("md_busy");
        PCSrcE = 1;
        step("md_busy_br");
        check_eq("md_br_masked", 32'(last0[4]), 32'd0);
        PCSrcE = 0;
        step("md_busy");
        MdDoneE = 1;
        step("md_done");
        MdDoneE = 0; MdOpE = 0;
        step("md_idle");
        cnt_md = 1'b0;
        check_eq("md_stallE_cycles", n_se, 5);
        check_eq("md_busy_cycles", n_bz, 4);
        check_eq("md_start_pulses", n_st, 1);
        MdDoneE = 1;
        step("done_in_idle");
        clr();

        // reset in BUSY cycle 2
        MdOpE = 1;
        step("md2_start");
        step("md2_busy1");
        rst_n = 1'b0; MdOpE = 0;
        #1;
        check_eq("rst_busy_drop", 32'(bz0), 32'd0);
        check_eq("rst_stall_drop", 32'(se0), 32'd0);
        step("md2_in_reset");
        rst_n = 1'b1; MdOpE = 1;
        step("md2_restart");
        check_eq("restart_start", 32'(last0[1]), 32'd1);
        MdDoneE = 1;
        step("md2_done");
        clr();

        // random mix
        for (int i = 0; i < 40; i++) begin
            Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
            Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
            RdE  = AW'($urandom_range(0, 3)); RdM  = AW'($urandom_range(0, 3));
            RdW  = AW'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1)); ResultSrcb0E = 1'($urandom_range(0, 1));
            PCSrcE  = ($urandom_range(0, 3) == 0);
            MdOpE   = ($urandom_range(0, 5) == 0);
            MdDoneE = ($urandom_range(0, 2) == 0);
            PerfClr = ($urandom_range(0, 9) == 0);
            step("rand");
        end
        clr();
        MdDoneE = 1;
        step("drain");
        clr();

`ifdef HAZARD_PERF_CNT_EN
        PerfClr = 1;
        step("cnt_clr");
        PerfClr = 0;
        check_eq("cnt_clr_s0", scnt0, 32'd0);
        ResultSrcb0E = 1; RdE = 7; Rs1D = 7;
        repeat (3) step("cnt_lw");
        clr();
        PCSrcE = 1;
        repeat (2) step("cnt_br");
        clr();
        check_eq("cnt_s0", scnt0, 32'd3);
        check_eq("cnt_f0", fcnt0, 32'd5);
        check_eq("cnt_f1_sat", 32'(fcnt1), 32'd3);
        ResultSrcb0E = 1; RdE = 7; Rs1D = 7;
        repeat (2) step("cnt_lw2");
        clr();
        step("cnt_end");
        check_eq("cnt_s0_5", scnt0, 32'd5);
        check_eq("cnt_s1_sat", 32'(scnt1), 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
